// File: rtl/drac_pkg.sv
// Shared types for the branch resolve controller: FSM states and the
// registered resolved-branch record.
package drac_pkg;

    localparam int unsigned DRAC_XLEN   = 64;
    localparam int unsigned DRAC_CHKP_W = 2;
    localparam int unsigned DRAC_CNT_W  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECOVER = 2'd1,
        DRAIN   = 2'd2
    } br_res_state_t;

    typedef struct packed {
        logic [DRAC_XLEN-1:0]   pc;
        logic                   taken;
        logic [DRAC_XLEN-1:0]   target;
        logic                   pred_taken;
        logic [DRAC_XLEN-1:0]   pred_addr;
        logic [DRAC_CHKP_W-1:0] chkp;
        logic                   chkp_done;
        logic                   is_jump;
        logic                   ex_valid;
    } br_res_t;

    // Jumps resolve taken regardless of the branch unit's direction bit.
    function automatic logic eff_taken(input br_res_t b);
        return b.taken | b.is_jump;
    endfunction

endpackage

// File: rtl/br_mispred_detect.sv
// Combinational mispredict compare and corrected fetch address for one
// resolved branch.
module br_mispred_detect #(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_taken,
    input  logic [XLEN-1:0] i_target,
    input  logic            i_pred_taken,
    input  logic [XLEN-1:0] i_pred_addr,
    output logic            o_mispred,
    output logic [XLEN-1:0] o_fix_pc
);

    logic w_dir_miss;
    logic w_tgt_miss;

    assign w_dir_miss = i_taken != i_pred_taken;
    assign w_tgt_miss = i_taken & (i_pred_addr != i_target);
    assign o_mispred  = w_dir_miss | w_tgt_miss;

    // Fall-through wraps at the top of the address space.
    assign o_fix_pc   = i_taken ? i_target : (i_pc + XLEN'(4));

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Registers resolved branches, raises redirect / checkpoint recovery /
// predictor update, and back-pressures branch issue during recovery.
module branch_resolve_ctrl
    import drac_pkg::*;
#(
    parameter int unsigned XLEN   = DRAC_XLEN,
    parameter int unsigned CHKP_W = DRAC_CHKP_W,
    parameter int unsigned CNT_W  = DRAC_CNT_W
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              kill_i,
    input  logic              br_valid_i,
    input  logic [XLEN-1:0]   br_pc_i,
    input  logic              br_taken_i,
    input  logic [XLEN-1:0]   br_target_i,
    input  logic              br_is_jump_i,
    input  logic              br_ex_valid_i,
    input  logic              pred_taken_i,
    input  logic [XLEN-1:0]   pred_addr_i,
    input  logic [CHKP_W-1:0] br_chkp_i,
    input  logic              br_chkp_done_i,
    output logic              br_ready_o,
    output logic              redirect_valid_o,
    output logic [XLEN-1:0]   redirect_pc_o,
    output logic              recover_req_o,
    output logic [CHKP_W-1:0] recover_chkp_o,
    input  logic              recover_ack_i,
    output logic              bpu_upd_valid_o,
    output logic [XLEN-1:0]   bpu_upd_pc_o,
    output logic              bpu_upd_taken_o,
    output logic [XLEN-1:0]   bpu_upd_target_o,
    output logic [CNT_W-1:0]  cnt_branch_o,
    output logic [CNT_W-1:0]  cnt_mispred_o
);

    br_res_state_t     r_state;
    br_res_state_t     w_state_nxt;
    br_res_t           r_br;
    logic              r_br_vld;
    logic [CHKP_W-1:0] r_chkp;
    logic [CNT_W-1:0]  r_cnt_branch;
    logic [CNT_W-1:0]  r_cnt_mispred;

    logic              w_take;
    logic              w_live;
    logic              w_act;
    logic              w_taken;
    logic              w_mispred;
    logic [XLEN-1:0]   w_fix_pc;
    logic              w_fire;
    logic              w_ready;
    logic              w_ld_chkp;

    assign w_take  = br_valid_i & br_ready_o & ~kill_i;
    assign w_live  = r_br_vld & ~kill_i;
    assign w_act   = w_live & ~r_br.ex_valid;
    assign w_taken = eff_taken(r_br);

    br_mispred_detect #(
        .XLEN (XLEN)
    ) u_detect (
        .i_pc         (r_br.pc),
        .i_taken      (w_taken),
        .i_target     (r_br.target),
        .i_pred_taken (r_br.pred_taken),
        .i_pred_addr  (r_br.pred_addr),
        .o_mispred    (w_mispred),
        .o_fix_pc     (w_fix_pc)
    );

    assign w_fire = w_act & w_mispred & (r_state == IDLE);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_br_vld <= 1'b0;
            r_br     <= '0;
        end else begin
            r_br_vld <= w_take;
            if (w_take) begin
                r_br.pc         <= br_pc_i;
                r_br.taken      <= br_taken_i;
                r_br.target     <= br_target_i;
                r_br.pred_taken <= pred_taken_i;
                r_br.pred_addr  <= pred_addr_i;
                r_br.chkp       <= br_chkp_i;
                r_br.chkp_done  <= br_chkp_done_i;
                r_br.is_jump    <= br_is_jump_i;
                r_br.ex_valid   <= br_ex_valid_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
            r_chkp  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ld_chkp) begin
                r_chkp <= r_br.chkp;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld_chkp   = 1'b0;
        w_ready     = 1'b0;
        if (kill_i) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_fire) begin
                        w_state_nxt = r_br.chkp_done ? RECOVER : DRAIN;
                        w_ld_chkp   = r_br.chkp_done;
                    end
                end
                RECOVER: begin
                    if (recover_ack_i) begin
                        w_state_nxt = DRAIN;
                    end
                end
                DRAIN:   w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
        // Issue is held off for the detection cycle as well as RECOVER/DRAIN.
        if ((r_state == IDLE) && !w_fire) begin
            w_ready = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt_branch  <= '0;
            r_cnt_mispred <= '0;
        end else begin
            if (w_live) begin
                r_cnt_branch <= r_cnt_branch + 1'b1;
            end
            if (w_fire) begin
                r_cnt_mispred <= r_cnt_mispred + 1'b1;
            end
        end
    end

    assign br_ready_o       = w_ready;
    assign redirect_valid_o = w_fire;
    assign redirect_pc_o    = w_fire ? w_fix_pc : '0;
    assign recover_req_o    = (r_state == RECOVER);
    assign recover_chkp_o   = (r_state == RECOVER) ? r_chkp : '0;
    assign bpu_upd_valid_o  = w_act;
    assign bpu_upd_pc_o     = w_act ? r_br.pc : '0;
    assign bpu_upd_taken_o  = w_act & w_taken;
    assign bpu_upd_target_o = w_act ? r_br.target : '0;
    assign cnt_branch_o     = r_cnt_branch;
    assign cnt_mispred_o    = r_cnt_mispred;

    a_no_issue_when_stalled: assert property (
        @(posedge clk_i) disable iff (!rstn_i) !(br_valid_i && !br_ready_o)
    );

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed vector table,
// multi-cycle corner sequences and randomized traffic against a cycle model.
module tb_branch_resolve_ctrl;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        kill_i = 1'b0;
    logic        br_valid_i = 1'b0;
    logic [63:0] br_pc_i = '0;
    logic        br_taken_i = 1'b0;
    logic [63:0] br_target_i = '0;
    logic        br_is_jump_i = 1'b0;
    logic        br_ex_valid_i = 1'b0;
    logic        pred_taken_i = 1'b0;
    logic [63:0] pred_addr_i = '0;
    logic [1:0]  br_chkp_i = '0;
    logic        br_chkp_done_i = 1'b0;
    logic        recover_ack_i = 1'b0;
    logic        br_ready_o, redirect_valid_o, recover_req_o;
    logic        bpu_upd_valid_o, bpu_upd_taken_o;
    logic [63:0] redirect_pc_o, bpu_upd_pc_o, bpu_upd_target_o;
    logic [1:0]  recover_chkp_o;
    logic [31:0] cnt_branch_o, cnt_mispred_o;

    always #5 clk_i = ~clk_i;

    branch_resolve_ctrl #(.XLEN(64), .CHKP_W(2), .CNT_W(32)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .kill_i(kill_i),
        .br_valid_i(br_valid_i), .br_pc_i(br_pc_i), .br_taken_i(br_taken_i),
        .br_target_i(br_target_i), .br_is_jump_i(br_is_jump_i),
        .br_ex_valid_i(br_ex_valid_i), .pred_taken_i(pred_taken_i),
        .pred_addr_i(pred_addr_i), .br_chkp_i(br_chkp_i),
        .br_chkp_done_i(br_chkp_done_i), .br_ready_o(br_ready_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .recover_req_o(recover_req_o), .recover_chkp_o(recover_chkp_o),
        .recover_ack_i(recover_ack_i), .bpu_upd_valid_o(bpu_upd_valid_o),
        .bpu_upd_pc_o(bpu_upd_pc_o), .bpu_upd_taken_o(bpu_upd_taken_o),
        .bpu_upd_target_o(bpu_upd_target_o), .cnt_branch_o(cnt_branch_o),
        .cnt_mispred_o(cnt_mispred_o)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] target;
        logic [63:0] pred_addr;
        logic [1:0]  chkp;
        logic        taken;
        logic        jump;
        logic        ex;
        logic        pred;
        logic        done;
    } br_t;

    typedef struct {
        br_t         b;
        logic        e_redir;
        logic [63:0] e_rpc;
        logic        e_req;
        logic        e_bpu;
        logic        e_bpu_taken;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: at most one branch waiting to be judged, a flag for an
    // outstanding restore request and a count of drain cycles left.
    br_t         m_pend[$];
    logic        m_wait;
    int          m_drain;
    logic [1:0]  m_chkp;
    logic [31:0] m_cb, m_cm;

    logic        e_has, e_redir, e_req, e_ready, e_bpu, e_bpu_taken;
    logic [63:0] e_rpc, e_bpu_pc, e_bpu_tgt;
    logic [1:0]  e_chkp;
    br_t         e_b;

    logic        s_redir, s_req, s_ready, s_bpu, s_bpu_taken;
    logic [63:0] s_rpc;
    logic [1:0]  s_chkp;
    logic [31:0] s_cb, s_cm;

    function automatic br_t mkbr(input logic [63:0] pc, input logic taken,
                                 input logic [63:0] target, input logic jump,
                                 input logic ex, input logic pred,
                                 input logic [63:0] pa, input logic [1:0] chkp,
                                 input logic done);
        br_t b;
        b.pc = pc; b.taken = taken; b.target = target; b.jump = jump;
        b.ex = ex; b.pred = pred; b.pred_addr = pa; b.chkp = chkp; b.done = done;
        return b;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend.delete();
        m_wait = 1'b0; m_drain = 0; m_chkp = '0; m_cb = '0; m_cm = '0;
    endtask

    task automatic model_eval(input logic kill);
        logic tk, mis;
        e_has = (m_pend.size() > 0) && !kill;
        e_b   = (m_pend.size() > 0) ? m_pend[0] : '0;
        tk    = e_b.taken | e_b.jump;
        mis   = (tk != e_b.pred) || (tk && (e_b.pred_addr != e_b.target));
        e_redir     = e_has && !e_b.ex && mis;
        e_rpc       = e_redir ? (tk ? e_b.target : e_b.pc + 64'd4) : 64'd0;
        e_bpu       = e_has && !e_b.ex;
        e_bpu_pc    = e_bpu ? e_b.pc : 64'd0;
        e_bpu_taken = e_bpu && tk;
        e_bpu_tgt   = e_bpu ? e_b.target : 64'd0;
        e_req       = m_wait;
        e_chkp      = m_wait ? m_chkp : 2'd0;
        e_ready     = !m_wait && (m_drain == 0) && !e_redir;
    endtask

    task automatic model_update(input logic kill, input logic ack,
                                input logic took, input br_t b);
        if (e_has) m_cb++;
        if (e_redir) m_cm++;
        m_pend.delete();
        if (kill) begin
            m_wait = 1'b0; m_drain = 0;
        end else begin
            if (m_wait) begin
                if (ack) begin m_wait = 1'b0; m_drain = 1; end
            end else if (m_drain > 0) begin
                m_drain--;
            end
            if (e_redir) begin
                if (e_b.done) begin m_wait = 1'b1; m_chkp = e_b.chkp; end
                else m_drain = 1;
            end
            if (took) m_pend.push_back(b);
        end
    endtask

    // One clock cycle; entered and left 1 time unit after a rising edge.
    task automatic step(input logic kill, input logic valid, input br_t b, input logic ack);
        logic took;
        kill_i = kill;
        recover_ack_i = ack;
        model_eval(kill);
        took = valid && e_ready;
        br_valid_i = took;
        br_pc_i = b.pc; br_taken_i = b.taken; br_target_i = b.target;
        br_is_jump_i = b.jump; br_ex_valid_i = b.ex; pred_taken_i = b.pred;
        pred_addr_i = b.pred_addr; br_chkp_i = b.chkp; br_chkp_done_i = b.done;
        @(negedge clk_i);
        s_redir = redirect_valid_o; s_rpc = redirect_pc_o; s_req = recover_req_o;
        s_chkp = recover_chkp_o; s_ready = br_ready_o; s_bpu = bpu_upd_valid_o;
        s_bpu_taken = bpu_upd_taken_o; s_cb = cnt_branch_o; s_cm = cnt_mispred_o;
        chk("redirect_valid", s_redir, e_redir);
        chk("redirect_pc", s_rpc, e_rpc);
        chk("recover_req", s_req, e_req);
        chk("recover_chkp", s_chkp, e_chkp);
        chk("br_ready", s_ready, e_ready);
        chk("bpu_valid", s_bpu, e_bpu);
        chk("bpu_pc", bpu_upd_pc_o, e_bpu_pc);
        chk("bpu_taken", s_bpu_taken, e_bpu_taken);
        chk("bpu_target", bpu_upd_target_o, e_bpu_tgt);
        chk("cnt_branch", s_cb, m_cb);
        chk("cnt_mispred", s_cm, m_cm);
        @(posedge clk_i);
        model_update(kill, ack, took, b);
        #1;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_ready"}, br_ready_o, 64'd1);
        chk({nm, "_redir"}, redirect_valid_o, 64'd0);
        chk({nm, "_rpc"}, redirect_pc_o, 64'd0);
        chk({nm, "_req"}, recover_req_o, 64'd0);
        chk({nm, "_chkp"}, recover_chkp_o, 64'd0);
        chk({nm, "_bpu"}, bpu_upd_valid_o, 64'd0);
        chk({nm, "_bpu_pc"}, bpu_upd_pc_o, 64'd0);
        chk({nm, "_bpu_tk"}, bpu_upd_taken_o, 64'd0);
        chk({nm, "_bpu_tgt"}, bpu_upd_target_o, 64'd0);
        chk({nm, "_cnt_b"}, cnt_branch_o, 64'd0);
        chk({nm, "_cnt_m"}, cnt_mispred_o, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[9];
        br_t  z, b;
        int   reqc;
        logic [31:0] cm0;

        z = '0;
        tv[0] = '{mkbr(64'h1000, 0, 64'h1234, 0, 0, 0, 64'h0,    2'd0, 0), 0, 64'h0,    0, 1, 0};
        tv[1] = '{mkbr(64'h2000, 1, 64'h2400, 0, 0, 0, 64'h0,    2'd2, 1), 1, 64'h2400, 1, 1, 1};
        tv[2] = '{mkbr(64'h3000, 1, 64'h3008, 0, 0, 1, 64'h3010, 2'd1, 0), 1, 64'h3008, 0, 1, 1};
        tv[3] = '{mkbr(64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h8000, 0, 0, 1, 64'h8000, 2'd3, 1), 1, 64'h0, 1, 1, 0};
        tv[4] = '{mkbr(64'h4000, 1, 64'h4800, 0, 1, 0, 64'h0,    2'd1, 1), 0, 64'h0,    0, 0, 0};
        tv[5] = '{mkbr(64'h5000, 0, 64'h5abc, 1, 0, 1, 64'h5abc, 2'd0, 1), 0, 64'h0,    0, 1, 1};
        tv[6] = '{mkbr(64'h6000, 1, 64'h6100, 0, 0, 1, 64'h6100, 2'd0, 0), 0, 64'h0,    0, 1, 1};
        tv[7] = '{mkbr(64'h7000, 0, 64'h7800, 1, 0, 0, 64'h0,    2'd1, 0), 1, 64'h7800, 0, 1, 1};
        tv[8] = '{mkbr(64'h9000, 0, 64'h9100, 0, 0, 1, 64'h9100, 2'd0, 0), 1, 64'h9004, 0, 1, 0};

        model_reset();
        @(negedge clk_i);
        chk_reset_outputs("rst");
        @(posedge clk_i);
        #1 rstn_i = 1'b1;

        // First vector: correct not-taken branch, counters after it.
        for (int i = 0; i < 9; i++) begin
            step(0, 1, tv[i].b, 0);
            step(0, 0, z, 0);
            chk("tv_redir", s_redir, tv[i].e_redir);
            chk("tv_rpc", s_rpc, tv[i].e_rpc);
            chk("tv_bpu", s_bpu, tv[i].e_bpu);
            chk("tv_bpu_taken", s_bpu_taken, tv[i].e_bpu_taken);
            step(0, 0, z, 0);
            chk("tv_req", s_req, tv[i].e_req);
            if (i == 0) begin
                chk("tv0_cnt_b", s_cb, 64'd1);
                chk("tv0_cnt_m", s_cm, 64'd0);
            end
            for (int k = 0; k < 4; k++) step(0, 0, z, 1);
        end

        // Restore request held three cycles until ack, then one drain cycle.
        b = mkbr(64'h2000, 1, 64'h2400, 0, 0, 0, 64'h0, 2'd2, 1);
        step(0, 1, b, 0);
        step(0, 0, z, 0);
        chk("seqA_redir", s_redir, 64'd1);
        chk("seqA_ready_detect", s_ready, 64'd0);
        reqc = 0;
        step(0, 0, z, 0); reqc += int'(s_req);
        step(0, 0, z, 0); reqc += int'(s_req);
        step(0, 0, z, 1); reqc += int'(s_req);
        chk("seqA_chkp", s_chkp, 64'd2);
        chk("seqA_req_cycles", reqc, 64'd3);
        step(0, 0, z, 0);
        chk("seqA_drain_req", s_req, 64'd0);
        chk("seqA_drain_ready", s_ready, 64'd0);
        step(0, 0, z, 0);
        chk("seqA_idle_ready", s_ready, 64'd1);

        // Ack in the first cycle the request is raised.
        step(0, 1, b, 0);
        step(0, 0, z, 0);
        step(0, 0, z, 1);
        chk("seqB_req", s_req, 64'd1);
        step(0, 0, z, 0);
        chk("seqB_drain_req", s_req, 64'd0);
        chk("seqB_drain_ready", s_ready, 64'd0);
        step(0, 0, z, 0);
        chk("seqB_ready", s_ready, 64'd1);

        // Kill while restoring.
        step(0, 1, b, 0);
        step(0, 0, z, 0);
        step(0, 0, z, 0);
        chk("seqC_req", s_req, 64'd1);
        step(1, 0, z, 0);
        step(0, 0, z, 0);
        chk("seqC_req_drop", s_req, 64'd0);
        chk("seqC_ready", s_ready, 64'd1);

        // Kill in the detection cycle.
        step(0, 1, b, 0);
        cm0 = cnt_mispred_o;
        step(1, 0, z, 0);
        chk("seqD_redir", s_redir, 64'd0);
        chk("seqD_ready", s_ready, 64'd1);
        step(0, 0, z, 0);
        chk("seqD_req", s_req, 64'd0);
        chk("seqD_cnt_m", s_cm, cm0);

        // Asynchronous reset while a restore is outstanding.
        step(0, 1, b, 0);
        step(0, 0, z, 0);
        step(0, 0, z, 0);
        chk("seqE_req_before", s_req, 64'd1);
        rstn_i = 1'b0;
        #1;
        chk_reset_outputs("arst");
        model_reset();
        @(posedge clk_i);
        #1 rstn_i = 1'b1;

        for (int n = 0; n < 2000; n++) begin
            b.pc     = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 15) == 0) b.pc = 64'hFFFF_FFFF_FFFF_FFFC;
            b.target = {$urandom, $urandom} & ~64'h1;
            b.taken  = 1'($urandom_range(0, 1));
            b.jump   = ($urandom_range(0, 7) == 0);
            b.ex     = ($urandom_range(0, 9) == 0);
            b.chkp   = 2'($urandom_range(0, 3));
            b.done   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                b.pred = b.taken | b.jump;
                b.pred_addr = b.target;
            end else begin
                b.pred = 1'($urandom_range(0, 1));
                b.pred_addr = ($urandom_range(0, 1) == 1) ? b.target : {$urandom, $urandom};
            end
            step($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6, b,
                 $urandom_range(0, 2) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
